// File: rtl/uart_rx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_rx_fifo                                               |
// | Description : FWFT receive FIFO behind uart_rx with overflow and error   |
// |               counting.                                                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module uart_rx_fifo #(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 16,
    parameter int AF_LEVEL  = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_BITS-1:0]     rx_data,
    input  logic                     rx_valid,
    input  logic                     rx_error,
    output logic [DATA_BITS-1:0]     rd_data,
    output logic                     rd_err,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_full,
    output logic                     overflow,
    input  logic                     clr_overflow,
    output logic [7:0]               err_cnt
);

    localparam int                c_AW       = $clog2(DEPTH);
    localparam int                c_CW       = c_AW + 1;
    localparam logic [c_AW-1:0]   c_PTR_ONE  = c_AW'(1);
    localparam logic [c_CW-1:0]   c_CNT_ONE  = c_CW'(1);
    localparam logic [c_CW-1:0]   c_DEPTH    = c_CW'(DEPTH);
    localparam logic [c_CW-1:0]   c_AF_LEVEL = c_CW'(AF_LEVEL);
    localparam logic [7:0]        c_ERR_MAX  = 8'hFF;

    // Each entry carries the error flag in its MSB above the data bits.
    logic [DATA_BITS:0] r_mem [DEPTH];
    logic [c_AW-1:0]    r_wr_ptr;
    logic [c_AW-1:0]    r_rd_ptr;
    logic [c_CW-1:0]    r_count;
    logic               r_empty;
    logic               r_full;
    logic               r_almost_full;
    logic               r_overflow;
    logic [7:0]         r_err_cnt;

    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic [c_CW-1:0]    w_count_nxt;
    logic [DATA_BITS:0] w_head;

    assign w_pop  = !r_empty && rd_ready;
    assign w_push = rx_valid && (!r_full || w_pop);
    assign w_drop = rx_valid && !w_push;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + c_CNT_ONE;
            2'b01:   w_count_nxt = r_count - c_CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage is cleared on reset so the head reads as zero and no stale entry survives.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= {rx_error, rx_data};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_empty       <= 1'b1;
            r_full        <= 1'b0;
            r_almost_full <= 1'b0;
            r_overflow    <= 1'b0;
            r_err_cnt     <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_count       <= w_count_nxt;
            r_empty       <= (w_count_nxt == '0);
            r_full        <= (w_count_nxt == c_DEPTH);
            r_almost_full <= (w_count_nxt >= c_AF_LEVEL);
            // A new drop wins over a coincident clear.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_overflow) begin
                r_overflow <= 1'b0;
            end
            if (w_push && rx_error && (r_err_cnt != c_ERR_MAX)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign w_head      = r_mem[r_rd_ptr];
    assign rd_data     = w_head[DATA_BITS-1:0];
    assign rd_err      = w_head[DATA_BITS];
    assign rd_valid    = !r_empty;
    assign count       = r_count;
    assign empty       = r_empty;
    assign full        = r_full;
    assign almost_full = r_almost_full;
    assign overflow    = r_overflow;
    assign err_cnt     = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_uart_rx_fifo                                            |
// | Description : Self-checking bench for uart_rx_fifo with a queue model.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_uart_rx_fifo;

    localparam int DEPTH    = 16;
    localparam int AF_LEVEL = 12;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic       rx_error = 1'b0;
    logic [7:0] rd_data;
    logic       rd_err;
    logic       rd_valid;
    logic       rd_ready = 1'b0;
    logic [4:0] count;
    logic       empty;
    logic       full;
    logic       almost_full;
    logic       overflow;
    logic       clr_overflow = 1'b0;
    logic [7:0] err_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: a queue of {err, data} plus sticky overflow and error count.
    logic [8:0] mq[$];
    bit         m_ov;
    int         m_err;

    uart_rx_fifo #(.DATA_BITS(8), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_error(rx_error), .rd_data(rd_data), .rd_err(rd_err),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .count(count),
        .empty(empty), .full(full), .almost_full(almost_full),
        .overflow(overflow), .clr_overflow(clr_overflow), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic step(input logic v, input logic [7:0] d, input logic e,
                        input logic r, input logic c);
        bit pop, push;
        rx_valid = v; rx_data = d; rx_error = e; rd_ready = r; clr_overflow = c;
        @(posedge clk);
        if (!rst_n) begin
            mq.delete(); m_ov = 0; m_err = 0;
        end else begin
            pop  = (mq.size() > 0) && r;
            push = v && ((mq.size() < DEPTH) || pop);
            if (v && !push) m_ov = 1;
            else if (c) m_ov = 0;
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back({e, d});
                if (e && m_err < 255) m_err++;
            end
        end
        #1;
        rx_valid = 0; rd_ready = 0; clr_overflow = 0;
    endtask

    task automatic test_reset;
        rst_n = 0;
        step(0, 8'h00, 0, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        rst_n = 1;
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (empty !== 1'b1 || full !== 1'b0 || almost_full !== 1'b0) begin
            errors++; $display("FAIL reset_flags got e%b f%b af%b exp e1 f0 af0", empty, full, almost_full); end
        checks++; if (rd_valid !== 1'b0 || overflow !== 1'b0) begin
            errors++; $display("FAIL reset_valid_ov got v%b ov%b exp 0 0", rd_valid, overflow); end
        checks++; if (err_cnt !== 8'd0 || rd_data !== 8'h00 || rd_err !== 1'b0) begin
            errors++; $display("FAIL reset_data got ec%0d d%h e%b exp 0 00 0", err_cnt, rd_data, rd_err); end
    endtask

    task automatic test_single;
        step(1, 8'hAA, 0, 0, 0);
        checks++; if (rd_valid !== 1'b1 || rd_data !== 8'hAA || rd_err !== 1'b0 || count !== 5'd1) begin
            errors++; $display("FAIL single_push got v%b d%h e%b c%0d exp v1 dAA e0 c1", rd_valid, rd_data, rd_err, count); end
        step(0, 8'h00, 0, 1, 0);
        checks++; if (empty !== 1'b1 || count !== 5'd0) begin
            errors++; $display("FAIL single_pop got e%b c%0d exp e1 c0", empty, count); end
    endtask

    task automatic test_fill_drain;
        for (int i = 0; i < DEPTH; i++) begin
            step(1, 8'(i), 0, 0, 0);
            checks++; if (count !== 5'(i + 1) || almost_full !== (i + 1 >= AF_LEVEL)) begin
                errors++; $display("FAIL fill_%0d got c%0d af%b exp c%0d af%b", i, count, almost_full, i + 1, (i + 1 >= AF_LEVEL)); end
        end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got %b exp 1", full); end
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (rd_valid !== 1'b1 || rd_data !== 8'(i)) begin
                errors++; $display("FAIL drain_%0d got v%b d%h exp v1 d%h", i, rd_valid, rd_data, 8'(i)); end
            step(0, 8'h00, 0, 1, 0);
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %b exp 1", empty); end
    endtask

    task automatic test_overflow;
        for (int i = 0; i < DEPTH; i++) step(1, 8'(i), 0, 0, 0);
        step(1, 8'h55, 0, 0, 0);
        checks++; if (overflow !== 1'b1 || count !== 5'd16 || rd_data !== 8'h00) begin
            errors++; $display("FAIL ovf_drop got ov%b c%0d d%h exp ov1 c16 d00", overflow, count, rd_data); end
        step(0, 8'h00, 0, 0, 1);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", overflow); end
        step(1, 8'h66, 0, 0, 1);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got %b exp 1", overflow); end
        step(0, 8'h00, 0, 0, 1);
    endtask

    task automatic test_full_push_pop;
        step(1, 8'h77, 0, 1, 0);
        checks++; if (count !== 5'd16 || overflow !== 1'b0 || full !== 1'b1) begin
            errors++; $display("FAIL fpp_state got c%0d ov%b f%b exp c16 ov0 f1", count, overflow, full); end
        for (int i = 1; i < DEPTH; i++) begin
            checks++; if (rd_data !== 8'(i)) begin
                errors++; $display("FAIL fpp_order_%0d got %h exp %h", i, rd_data, 8'(i)); end
            step(0, 8'h00, 0, 1, 0);
        end
        checks++; if (rd_valid !== 1'b1 || rd_data !== 8'h77 || count !== 5'd1) begin
            errors++; $display("FAIL fpp_last got v%b d%h c%0d exp v1 d77 c1", rd_valid, rd_data, count); end
        step(0, 8'h00, 0, 1, 0);
    endtask

    task automatic test_err_saturation;
        for (int i = 0; i < 300; i++) begin
            if (rd_valid) begin
                checks++; if (rd_err !== 1'b1) begin
                    errors++; $display("FAIL errsat_flag_%0d got %b exp 1", i, rd_err); end
            end
            step(1, 8'($urandom), 1, 1, 0);
            checks++; if (err_cnt !== 8'(m_err)) begin
                errors++; $display("FAIL errsat_cnt_%0d got %0d exp %0d", i, err_cnt, m_err); end
        end
        checks++; if (err_cnt !== 8'd255) begin errors++; $display("FAIL errsat_final got %0d exp 255", err_cnt); end
        step(0, 8'h00, 0, 1, 0);
    endtask

    task automatic test_reset_mid_burst;
        for (int i = 0; i < 5; i++) step(1, 8'(8'h10 + i), 1, 0, 0);
        rst_n = 0;
        step(1, 8'hEE, 0, 0, 0);
        rst_n = 1;
        checks++; if (count !== 5'd0 || empty !== 1'b1 || rd_valid !== 1'b0 || overflow !== 1'b0 || err_cnt !== 8'd0) begin
            errors++; $display("FAIL midrst got c%0d e%b v%b ov%b ec%0d exp 0 1 0 0 0", count, empty, rd_valid, overflow, err_cnt); end
        step(1, 8'h3C, 0, 0, 0);
        checks++; if (rd_valid !== 1'b1 || rd_data !== 8'h3C || count !== 5'd1) begin
            errors++; $display("FAIL midrst_push got v%b d%h c%0d exp v1 d3C c1", rd_valid, rd_data, count); end
        step(0, 8'h00, 0, 1, 0);
    endtask

    task automatic test_random;
        int vp, rp;
        for (int i = 0; i < 3000; i++) begin
            vp = ((i / 200) % 2 == 0) ? 70 : 30;
            rp = 100 - vp;
            step($urandom_range(99) < vp, 8'($urandom), 1'($urandom), $urandom_range(99) < rp,
                 $urandom_range(99) < 3);
            checks++;
            if (count !== 5'(mq.size()) || empty !== (mq.size() == 0) || full !== (mq.size() == DEPTH) ||
                almost_full !== (mq.size() >= AF_LEVEL) || rd_valid !== (mq.size() != 0) ||
                overflow !== m_ov || err_cnt !== 8'(m_err) ||
                (mq.size() != 0 && {rd_err, rd_data} !== mq[0])) begin
                errors++;
                $display("FAIL random_%0d got c%0d ov%b ec%0d head %h exp c%0d ov%b ec%0d head %h",
                         i, count, overflow, err_cnt, {rd_err, rd_data}, mq.size(), m_ov, m_err,
                         (mq.size() != 0) ? mq[0] : 9'h0);
            end
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_fill_drain;
        test_overflow;
        test_full_push_pop;
        test_err_saturation;
        test_reset_mid_burst;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
